e203_exu_longpwbck_mc: RTL and testbench

Multi-channel, registered successor of the long-pipe writeback unit in the EXU. Arbitrates NCH long-pipe result sources (ch0 = LSU, ch1 = NICE, further channels for future coprocessors) strictly in OITF retire order. Routes each result to the regfile writeback port or the commit/exception port. Both output paths carry a one-entry registered stage with a ready/valid handshake, breaking the combinational path from OITF and source valid to the commit and regfile logic.

---
 rtl/e203_longpwbck_pkg.sv | 36 +++
 rtl/e203_longpwbck_oreg.sv | 42 ++++
 rtl/e203_exu_longpwbck_mc.sv | 127 ++++++++++++
 tb/tb_e203_exu_longpwbck_mc.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/e203_longpwbck_pkg.sv
// Shared definitions for the multi-channel long-pipe writeback unit:
// channel ids, payload layouts and payload width helpers.
package e203_longpwbck_pkg;

   localparam int unsigned CH_LSU      = 0;
   localparam int unsigned CH_NICE     = 1;
   localparam int unsigned CHID_W      = 3;
   localparam int unsigned PKG_XLEN    = 32;
   localparam int unsigned PKG_RFIDX_W = 5;

   typedef struct packed {
      logic [PKG_XLEN-1:0]    wdat;
      logic [PKG_RFIDX_W-1:0] rdidx;
      logic                   rdfpu;
      logic [CHID_W-1:0]      chid;
   } wbck_pld_t;

   typedef struct packed {
      logic                insterr;
      logic                ld;
      logic                st;
      logic                buserr;
      logic [PKG_XLEN-1:0] badaddr;
      logic [PKG_XLEN-1:0] pc;
   } excp_pld_t;

   // Flat widths matching the field order of the structs above, for any XLEN/RFIDX_W
   function automatic int unsigned wbck_pld_w(input int unsigned xlen, input int unsigned rfidx_w);
      return xlen + rfidx_w + 1 + CHID_W;
   endfunction

   function automatic int unsigned excp_pld_w(input int unsigned xlen);
      return 4 + 2 * xlen;
   endfunction

endpackage

// File: rtl/e203_longpwbck_oreg.sv
// One-entry registered output stage with valid/ready handshake.
// A load in the same cycle as a drain overwrites and keeps valid asserted.
module e203_longpwbck_oreg #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] din,
   input  logic         ready,
   output logic         valid,
   output logic [W-1:0] dout
);

   logic         valid_d, valid_q;
   logic [W-1:0] data_d,  data_q;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (load) begin
         valid_d = 1'b1;
         data_d  = din;
      end else if (ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid = valid_q;
   assign dout  = data_q;

endmodule

// File: rtl/e203_exu_longpwbck_mc.sv
// Multi-channel long-pipe writeback: retires results in OITF order and routes
// each to a registered regfile-writeback or exception output stage.
module e203_exu_longpwbck_mc
   import e203_longpwbck_pkg::*;
#(
   parameter int unsigned NCH     = 2,
   parameter int unsigned ITAG_W  = 1,
   parameter int unsigned XLEN    = 32,
   parameter int unsigned RFIDX_W = 5
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NCH-1:0]        src_valid,
   output logic [NCH-1:0]        src_ready,
   input  logic [NCH*XLEN-1:0]   src_wdat,
   input  logic [NCH*ITAG_W-1:0] src_itag,
   input  logic [NCH-1:0]        src_err,
   input  logic                  lsu_buserr,
   input  logic [XLEN-1:0]       lsu_badaddr,
   input  logic                  lsu_ld,
   input  logic                  lsu_st,
   input  logic                  oitf_empty,
   input  logic [ITAG_W-1:0]     oitf_ret_ptr,
   input  logic [RFIDX_W-1:0]    oitf_ret_rdidx,
   input  logic [XLEN-1:0]       oitf_ret_pc,
   input  logic                  oitf_ret_rdwen,
   input  logic                  oitf_ret_rdfpu,
   output logic                  oitf_ret_ena,
   output logic                  wbck_o_valid,
   input  logic                  wbck_o_ready,
   output logic [XLEN-1:0]       wbck_o_wdat,
   output logic [RFIDX_W-1:0]    wbck_o_rdidx,
   output logic                  wbck_o_rdfpu,
   output logic [2:0]            wbck_o_chid,
   output logic                  excp_o_valid,
   input  logic                  excp_o_ready,
   output logic                  excp_o_insterr,
   output logic                  excp_o_ld,
   output logic                  excp_o_st,
   output logic                  excp_o_buserr,
   output logic [XLEN-1:0]       excp_o_badaddr,
   output logic [XLEN-1:0]       excp_o_pc
);

   localparam int unsigned WB_W = wbck_pld_w(XLEN, RFIDX_W);
   localparam int unsigned EX_W = excp_pld_w(XLEN);

   logic [NCH-1:0]    hit;
   logic              any_hit;
   logic [CHID_W-1:0] sel;
   logic [XLEN-1:0]   sel_wdat;
   logic              sel_err;
   logic              need_wb, need_ex, wb_free, ex_free, acc;
   logic              wb_load, ex_load;
   logic [WB_W-1:0]   wb_din, wb_dout;
   logic [EX_W-1:0]   ex_din, ex_dout;

   always_comb begin
      hit      = '0;
      any_hit  = 1'b0;
      sel      = '0;
      sel_wdat = '0;
      sel_err  = 1'b0;
      for (int unsigned c = 0; c < NCH; c++) begin
         hit[c] = src_valid[c] & ~oitf_empty & (src_itag[c*ITAG_W +: ITAG_W] == oitf_ret_ptr);
         if (hit[c] && !any_hit) begin
            any_hit  = 1'b1;
            sel      = CHID_W'(c);
            sel_wdat = src_wdat[c*XLEN +: XLEN];
            sel_err  = src_err[c];
         end
      end
   end

   // Accept is held off during reset so no retire can leak out before the first edge
   always_comb begin
      need_wb = oitf_ret_rdwen & ~sel_err;
      need_ex = sel_err;
      wb_free = ~wbck_o_valid | wbck_o_ready;
      ex_free = ~excp_o_valid | excp_o_ready;
      acc     = rst_n & any_hit & (~need_wb | wb_free) & (~need_ex | ex_free);
      wb_load = acc & need_wb;
      ex_load = acc & need_ex;
      for (int unsigned c = 0; c < NCH; c++) begin
         src_ready[c] = acc & (sel == CHID_W'(c));
      end
   end

   assign oitf_ret_ena = acc;

   always_comb begin
      wb_din = {sel_wdat, oitf_ret_rdidx, oitf_ret_rdfpu, sel};
      if (sel == CHID_W'(CH_LSU)) begin
         ex_din = {1'b0, lsu_ld, lsu_st, lsu_buserr, lsu_badaddr, oitf_ret_pc};
      end else begin
         ex_din = {1'b1, 3'b000, {XLEN{1'b0}}, oitf_ret_pc};
      end
   end

   e203_longpwbck_oreg #(.W(WB_W)) u_wbck_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (wb_load),
      .din   (wb_din),
      .ready (wbck_o_ready),
      .valid (wbck_o_valid),
      .dout  (wb_dout)
   );

   e203_longpwbck_oreg #(.W(EX_W)) u_excp_reg (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (ex_load),
      .din   (ex_din),
      .ready (excp_o_ready),
      .valid (excp_o_valid),
      .dout  (ex_dout)
   );

   assign {wbck_o_wdat, wbck_o_rdidx, wbck_o_rdfpu, wbck_o_chid} = wb_dout;
   assign {excp_o_insterr, excp_o_ld, excp_o_st, excp_o_buserr,
           excp_o_badaddr, excp_o_pc} = ex_dout;

   // The OITF guarantees a single matching source; more than one is a source bug
   a_single_hit: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(hit));

endmodule

// File: tb/tb_e203_exu_longpwbck_mc.sv
// Bench for e203_exu_longpwbck_mc: directed vector table on a 2-channel instance,
// hand sequences for reset/empty, and a modelled random run on a 3-channel instance.
module tb_e203_exu_longpwbck_mc;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // ---------------- instance A: NCH=2, ITAG_W=1 ----------------
   logic [1:0]  src_valid, src_ready, src_itag, src_err;
   logic [63:0] src_wdat;
   logic        lsu_buserr, lsu_ld, lsu_st, oitf_empty;
   logic [31:0] lsu_badaddr, oitf_ret_pc;
   logic [0:0]  oitf_ret_ptr;
   logic [4:0]  oitf_ret_rdidx;
   logic        oitf_ret_rdwen, oitf_ret_rdfpu, oitf_ret_ena;
   logic        wv, wrdy, wfpu, ev, erdy, einst, eld, est, ebus;
   logic [31:0] wdat, ebad, epc;
   logic [4:0]  widx;
   logic [2:0]  wchid;

   e203_exu_longpwbck_mc #(.NCH(2), .ITAG_W(1), .XLEN(32), .RFIDX_W(5)) dut (
      .clk(clk), .rst_n(rst_n),
      .src_valid(src_valid), .src_ready(src_ready), .src_wdat(src_wdat),
      .src_itag(src_itag), .src_err(src_err),
      .lsu_buserr(lsu_buserr), .lsu_badaddr(lsu_badaddr), .lsu_ld(lsu_ld), .lsu_st(lsu_st),
      .oitf_empty(oitf_empty), .oitf_ret_ptr(oitf_ret_ptr), .oitf_ret_rdidx(oitf_ret_rdidx),
      .oitf_ret_pc(oitf_ret_pc), .oitf_ret_rdwen(oitf_ret_rdwen), .oitf_ret_rdfpu(oitf_ret_rdfpu),
      .oitf_ret_ena(oitf_ret_ena),
      .wbck_o_valid(wv), .wbck_o_ready(wrdy), .wbck_o_wdat(wdat), .wbck_o_rdidx(widx),
      .wbck_o_rdfpu(wfpu), .wbck_o_chid(wchid),
      .excp_o_valid(ev), .excp_o_ready(erdy), .excp_o_insterr(einst), .excp_o_ld(eld),
      .excp_o_st(est), .excp_o_buserr(ebus), .excp_o_badaddr(ebad), .excp_o_pc(epc)
   );

   // ---------------- instance B: NCH=3, ITAG_W=2 ----------------
   logic [2:0]  r_valid, r_ready, r_err;
   logic [5:0]  r_itag;
   logic [95:0] r_wdat;
   logic        r_bus, r_ld, r_st, r_empty, r_rdwen, r_rdfpu, r_ena;
   logic [31:0] r_bad, r_pc;
   logic [1:0]  r_ptr;
   logic [4:0]  r_rdidx;
   logic        r_wv, r_wrdy, r_wfpu, r_ev, r_erdy, r_einst, r_eld, r_est, r_ebus;
   logic [31:0] r_wdat_o, r_ebad, r_epc;
   logic [4:0]  r_widx;
   logic [2:0]  r_wchid;

   e203_exu_longpwbck_mc #(.NCH(3), .ITAG_W(2), .XLEN(32), .RFIDX_W(5)) dut_r (
      .clk(clk), .rst_n(rst_n),
      .src_valid(r_valid), .src_ready(r_ready), .src_wdat(r_wdat),
      .src_itag(r_itag), .src_err(r_err),
      .lsu_buserr(r_bus), .lsu_badaddr(r_bad), .lsu_ld(r_ld), .lsu_st(r_st),
      .oitf_empty(r_empty), .oitf_ret_ptr(r_ptr), .oitf_ret_rdidx(r_rdidx),
      .oitf_ret_pc(r_pc), .oitf_ret_rdwen(r_rdwen), .oitf_ret_rdfpu(r_rdfpu),
      .oitf_ret_ena(r_ena),
      .wbck_o_valid(r_wv), .wbck_o_ready(r_wrdy), .wbck_o_wdat(r_wdat_o), .wbck_o_rdidx(r_widx),
      .wbck_o_rdfpu(r_wfpu), .wbck_o_chid(r_wchid),
      .excp_o_valid(r_ev), .excp_o_ready(r_erdy), .excp_o_insterr(r_einst), .excp_o_ld(r_eld),
      .excp_o_st(r_est), .excp_o_buserr(r_ebus), .excp_o_badaddr(r_ebad), .excp_o_pc(r_epc)
   );

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One directed cycle: inputs, then expected {src_ready, ret_ena} before the edge
   // and expected wb bundle {valid,wdat,rdidx,rdfpu,chid} / exc bundle
   // {valid,insterr,ld,st,buserr,badaddr,pc} after it.
   typedef struct {
      logic [1:0]  v, tag, err;
      logic        empty, ptr, rdwen, rdfpu;
      logic [4:0]  rdidx;
      logic [31:0] wd0, wd1, bad, pc;
      logic        bus, ld, st, wrdy, erdy;
      logic [1:0]  x_srdy;
      logic        x_rena;
      logic [41:0] x_wb;
      logic [68:0] x_ex;
   } vec_t;

   vec_t tv[14];

   task automatic apply_a(input vec_t t);
      src_valid = t.v; src_itag = t.tag; src_err = t.err; oitf_empty = t.empty;
      oitf_ret_ptr = t.ptr; oitf_ret_rdwen = t.rdwen; oitf_ret_rdfpu = t.rdfpu;
      oitf_ret_rdidx = t.rdidx; src_wdat = {t.wd1, t.wd0}; lsu_badaddr = t.bad;
      oitf_ret_pc = t.pc; lsu_buserr = t.bus; lsu_ld = t.ld; lsu_st = t.st;
      wrdy = t.wrdy; erdy = t.erdy;
   endtask

   // Reference model state for instance B
   logic        m_wv, m_wfpu, m_ev, m_einst, m_eld, m_est, m_ebus;
   logic [31:0] m_wdat, m_ebad, m_epc;
   logic [4:0]  m_widx;
   logic [2:0]  m_wchid;

   initial begin
      vec_t t;
      int   h;
      logic e_hit, nwb, nex, acc;
      logic [1:0] p, tg;
      logic [2:0] x_srdy;

      //         v      tag    err    em ptr wen fpu idx    wd0           wd1           bad           pc            bus ld st wr er  srdy  ena  wb-bundle                                   exc-bundle
      tv[0]  = '{2'b10, 2'b10, 2'b00, 0, 1, 1, 0, 5'd7,  32'h0,        32'hDEADBEEF, 32'h0,        32'h0,        0, 0, 0, 1, 1, 2'b10, 1, {1'b1,32'hDEADBEEF,5'd7,1'b0,3'd1},  69'h0};
      tv[1]  = '{2'b01, 2'b00, 2'b00, 0, 0, 1, 0, 5'd3,  32'h11111111, 32'h0,        32'h0,        32'h0,        0, 0, 0, 0, 1, 2'b00, 0, {1'b1,32'hDEADBEEF,5'd7,1'b0,3'd1},  69'h0};
      tv[2]  = '{2'b01, 2'b00, 2'b00, 0, 0, 1, 0, 5'd3,  32'h11111111, 32'h0,        32'h0,        32'h0,        0, 0, 0, 1, 1, 2'b01, 1, {1'b1,32'h11111111,5'd3,1'b0,3'd0},  69'h0};
      tv[3]  = '{2'b00, 2'b00, 2'b00, 0, 0, 1, 0, 5'd3,  32'h0,        32'h0,        32'h0,        32'h0,        0, 0, 0, 1, 1, 2'b00, 0, {1'b0,32'h11111111,5'd3,1'b0,3'd0},  69'h0};
      tv[4]  = '{2'b01, 2'b00, 2'b01, 0, 0, 1, 0, 5'd9,  32'h55,        32'h0,        32'h80000010, 32'h100,      1, 1, 0, 1, 0, 2'b01, 1, {1'b0,32'h11111111,5'd3,1'b0,3'd0},  {1'b1,1'b0,1'b1,1'b0,1'b1,32'h80000010,32'h100}};
      tv[5]  = '{2'b10, 2'b10, 2'b10, 0, 1, 1, 0, 5'd9,  32'h0,        32'h66,       32'hABC,      32'h200,      1, 1, 0, 1, 0, 2'b00, 0, {1'b0,32'h11111111,5'd3,1'b0,3'd0},  {1'b1,1'b0,1'b1,1'b0,1'b1,32'h80000010,32'h100}};
      tv[6]  = '{2'b10, 2'b10, 2'b10, 0, 1, 1, 0, 5'd9,  32'h0,        32'h66,       32'hABC,      32'h200,      1, 1, 0, 1, 1, 2'b10, 1, {1'b0,32'h11111111,5'd3,1'b0,3'd0},  {1'b1,1'b1,1'b0,1'b0,1'b0,32'h0,32'h200}};
      tv[7]  = '{2'b01, 2'b00, 2'b00, 0, 0, 0, 0, 5'd4,  32'h77,        32'h0,        32'h0,        32'h0,        0, 0, 0, 0, 0, 2'b01, 1, {1'b0,32'h11111111,5'd3,1'b0,3'd0},  {1'b1,1'b1,1'b0,1'b0,1'b0,32'h0,32'h200}};
      tv[8]  = '{2'b00, 2'b00, 2'b00, 0, 0, 0, 0, 5'd0,  32'h0,        32'h0,        32'h0,        32'h0,        0, 0, 0, 0, 1, 2'b00, 0, {1'b0,32'h11111111,5'd3,1'b0,3'd0},  {1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,32'h200}};
      tv[9]  = '{2'b01, 2'b01, 2'b00, 0, 0, 1, 0, 5'd5,  32'h88,        32'h0,        32'h0,        32'h0,        0, 0, 0, 1, 1, 2'b00, 0, {1'b0,32'h11111111,5'd3,1'b0,3'd0},  {1'b0,1'b1,1'b0,1'b0,1'b0,32'h0,32'h200}};
      tv[10] = '{2'b01, 2'b00, 2'b01, 0, 0, 1, 0, 5'd5,  32'h99,        32'h0,        32'h44,       32'h300,      0, 0, 1, 1, 1, 2'b01, 1, {1'b0,32'h11111111,5'd3,1'b0,3'd0},  {1'b1,1'b0,1'b0,1'b1,1'b0,32'h44,32'h300}};
      tv[11] = '{2'b10, 2'b10, 2'b00, 0, 1, 1, 1, 5'd31, 32'h0,        32'hCAFEF00D, 32'h0,        32'h0,        0, 0, 0, 0, 1, 2'b10, 1, {1'b1,32'hCAFEF00D,5'd31,1'b1,3'd1}, {1'b0,1'b0,1'b0,1'b1,1'b0,32'h44,32'h300}};
      tv[12] = '{2'b01, 2'b00, 2'b00, 0, 0, 1, 0, 5'd2,  32'h12345678, 32'h0,        32'h0,        32'h0,        0, 0, 0, 1, 0, 2'b01, 1, {1'b1,32'h12345678,5'd2,1'b0,3'd0},  {1'b0,1'b0,1'b0,1'b1,1'b0,32'h44,32'h300}};
      tv[13] = '{2'b11, 2'b10, 2'b00, 1, 0, 1, 0, 5'd2,  32'h1,        32'h2,        32'h0,        32'h0,        0, 0, 0, 1, 0, 2'b00, 0, {1'b0,32'h12345678,5'd2,1'b0,3'd0},  {1'b0,1'b0,1'b0,1'b1,1'b0,32'h44,32'h300}};

      // instance B idle until its random phase
      r_valid = '0; r_itag = '0; r_err = '0; r_wdat = '0; r_bus = 0; r_ld = 0; r_st = 0;
      r_bad = '0; r_pc = '0; r_empty = 1; r_ptr = '0; r_rdidx = '0; r_rdwen = 0; r_rdfpu = 0;
      r_wrdy = 1; r_erdy = 1;

      // ---- reset with sources valid ----
      rst_n = 0;
      t = tv[0];
      t.v = 2'b11; t.tag = 2'b10; t.ptr = 0; t.rdwen = 1; t.wrdy = 1; t.erdy = 1; t.wd0 = 32'hA5A5A5A5;
      t.rdidx = 5'd1; t.err = 2'b00;
      apply_a(t);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); #1;
         check("reset_ret_ena", {src_ready, oitf_ret_ena}, 3'b000);
         @(posedge clk); #1;
         check("reset_wb", {wv, wdat, widx, wfpu, wchid}, 42'h0);
         check("reset_ex", {ev, einst, eld, est, ebus, ebad, epc}, 69'h0);
      end
      @(negedge clk);
      rst_n = 1;
      t.v = 2'b01;
      apply_a(t);
      #1;
      check("post_reset_accept", {src_ready, oitf_ret_ena}, 3'b011);
      check("post_reset_wv_before_edge", wv, 1'b0);
      @(posedge clk); #1;
      check("post_reset_wb", {wv, wdat, widx, wfpu, wchid}, {1'b1, 32'hA5A5A5A5, 5'd1, 1'b0, 3'd0});

      // ---- OITF empty blocks a matching source ----
      t.empty = 1; t.v = 2'b01; t.tag = 2'b00; t.ptr = 0;
      apply_a(t);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk); #1;
         check("empty_blocks", {src_ready, oitf_ret_ena}, 3'b000);
      end

      // ---- directed table ----
      for (int i = 0; i < 14; i++) begin
         @(negedge clk);
         apply_a(tv[i]);
         #1;
         check($sformatf("row%0d_ready", i), {src_ready, oitf_ret_ena}, {tv[i].x_srdy, tv[i].x_rena});
         @(posedge clk); #1;
         check($sformatf("row%0d_wb", i), {wv, wdat, widx, wfpu, wchid}, tv[i].x_wb);
         check($sformatf("row%0d_ex", i), {ev, einst, eld, est, ebus, ebad, epc}, tv[i].x_ex);
      end
      @(negedge clk);
      src_valid = '0;

      // ---- random run on instance B against a reference model ----
      m_wv = 0; m_wdat = '0; m_widx = '0; m_wfpu = 0; m_wchid = '0;
      m_ev = 0; m_einst = 0; m_eld = 0; m_est = 0; m_ebus = 0; m_ebad = '0; m_epc = '0;
      for (int n = 0; n < 2000; n++) begin
         @(negedge clk);
         h = int'($urandom_range(0, 3));
         p = 2'($urandom_range(0, 3));
         r_empty = ($urandom_range(0, 4) == 0);
         r_ptr = p;
         for (int c = 0; c < 3; c++) begin
            r_valid[c] = (c == h) ? 1'b1 : 1'($urandom_range(0, 1));
            tg = (c == h) ? p : p + 2'($urandom_range(1, 3));
            r_itag[c*2 +: 2] = tg;
            r_wdat[c*32 +: 32] = $urandom;
            r_err[c] = ($urandom_range(0, 3) == 0);
         end
         r_rdwen = 1'($urandom_range(0, 1)); r_rdfpu = 1'($urandom_range(0, 1));
         r_rdidx = 5'($urandom_range(0, 31)); r_pc = $urandom; r_bad = $urandom;
         r_bus = 1'($urandom_range(0, 1)); r_ld = 1'($urandom_range(0, 1)); r_st = 1'($urandom_range(0, 1));
         r_wrdy = 1'($urandom_range(0, 1)); r_erdy = 1'($urandom_range(0, 1));

         e_hit = (h < 3) && !r_empty;
         nwb = 0; nex = 0; acc = 0; x_srdy = '0;
         if (e_hit) begin
            nex = r_err[h];
            nwb = r_rdwen && !r_err[h];
            acc = (!nwb || !m_wv || r_wrdy) && (!nex || !m_ev || r_erdy);
            if (acc) x_srdy[h] = 1'b1;
         end
         #1;
         check("rnd_ready", {r_ready, r_ena}, {x_srdy, acc});

         @(posedge clk);
         if (acc && nwb) begin
            m_wv = 1; m_wdat = r_wdat[h*32 +: 32]; m_widx = r_rdidx; m_wfpu = r_rdfpu; m_wchid = 3'(h);
         end else if (r_wrdy) m_wv = 0;
         if (acc && nex) begin
            m_ev = 1; m_epc = r_pc;
            if (h == 0) begin
               m_einst = 0; m_eld = r_ld; m_est = r_st; m_ebus = r_bus; m_ebad = r_bad;
            end else begin
               m_einst = 1; m_eld = 0; m_est = 0; m_ebus = 0; m_ebad = '0;
            end
         end else if (r_erdy) m_ev = 0;
         #1;
         check("rnd_wb", {r_wv, r_wdat_o, r_widx, r_wfpu, r_wchid}, {m_wv, m_wdat, m_widx, m_wfpu, m_wchid});
         check("rnd_ex", {r_ev, r_einst, r_eld, r_est, r_ebus, r_ebad, r_epc},
               {m_ev, m_einst, m_eld, m_est, m_ebus, m_ebad, m_epc});
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
